// File: rtl/sweep_scanner.sv
// Servo sweep sequencer: steps an angle between ANGLE_MIN and ANGLE_MAX, settles,
// takes one range measurement per step and emits (angle, range, dir, tmo) samples.
module sweep_scanner #(
    parameter int ANGLE_W     = 9,
    parameter int ANGLE_MIN   = 0,
    parameter int ANGLE_MAX   = 270,
    parameter int STEP        = 5,
    parameter int DWELL_CYC   = 2000000,
    parameter int TIMEOUT_CYC = 5000000,
    parameter int RANGE_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    output logic [ANGLE_W-1:0] servo_angle,
    output logic               meas_req,
    input  logic               meas_valid,
    input  logic [RANGE_W-1:0] range_in,
    output logic               sample_valid,
    output logic [ANGLE_W-1:0] sample_angle,
    output logic [RANGE_W-1:0] sample_range,
    output logic               sample_dir,
    output logic               sample_tmo,
    output logic               busy,
    output logic               sweep_done,
    output logic [2:0]         state_dbg
);

    localparam int AW1       = ANGLE_W + 1;
    localparam int DWELL_W   = $clog2(DWELL_CYC + 1);
    localparam int TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam int RESTART_I = (ANGLE_MIN + STEP > ANGLE_MAX) ? ANGLE_MAX : ANGLE_MIN + STEP;

    localparam logic [ANGLE_W-1:0] A_MIN     = ANGLE_W'(ANGLE_MIN);
    localparam logic [ANGLE_W-1:0] A_MAX     = ANGLE_W'(ANGLE_MAX);
    localparam logic [ANGLE_W-1:0] A_RESTART = ANGLE_W'(RESTART_I);
    localparam logic [AW1-1:0]     A_MIN_X   = AW1'(ANGLE_MIN);
    localparam logic [AW1-1:0]     A_MAX_X   = AW1'(ANGLE_MAX);
    localparam logic [AW1-1:0]     STEP_X    = AW1'(STEP);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYC - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_MEASURE = 3'd2,
        S_EMIT    = 3'd3,
        S_STEP    = 3'd4
    } state_t;

    state_t               state, state_n;
    logic [ANGLE_W-1:0]   angle, angle_n;
    logic                 dir, dir_n;
    logic [DWELL_W-1:0]   dwell_cnt, dwell_n;
    logic [TMO_W-1:0]     tmo_cnt, tmo_n;
    logic [ANGLE_W-1:0]   smp_angle, smp_angle_n;
    logic [RANGE_W-1:0]   smp_range, smp_range_n;
    logic                 smp_dir, smp_dir_n;
    logic                 smp_tmo, smp_tmo_n;
    logic [AW1-1:0]       up_sum, dn_diff;
    logic [ANGLE_W-1:0]   up_next, dn_next;

    // One extra bit so overshoot above ANGLE_MAX or a borrow below zero is visible before truncation.
    always_comb begin
        up_sum  = {1'b0, angle} + STEP_X;
        dn_diff = {1'b0, angle} - STEP_X;
        up_next = (up_sum > A_MAX_X) ? A_MAX : up_sum[ANGLE_W-1:0];
        dn_next = (dn_diff[ANGLE_W] || (dn_diff < A_MIN_X)) ? A_MIN : dn_diff[ANGLE_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            angle     <= A_MIN;
            dir       <= 1'b0;
            dwell_cnt <= '0;
            tmo_cnt   <= '0;
            smp_angle <= '0;
            smp_range <= '0;
            smp_dir   <= 1'b0;
            smp_tmo   <= 1'b0;
        end else begin
            state     <= state_n;
            angle     <= angle_n;
            dir       <= dir_n;
            dwell_cnt <= dwell_n;
            tmo_cnt   <= tmo_n;
            smp_angle <= smp_angle_n;
            smp_range <= smp_range_n;
            smp_dir   <= smp_dir_n;
            smp_tmo   <= smp_tmo_n;
        end
    end

    // Sensor handshake: meas_req is high for every MEASURE cycle; a meas_valid strobe seen while
    // meas_req is high completes the transfer (range_in captured that cycle), and meas_req drops
    // the next cycle. meas_valid while meas_req is low carries no meaning and is ignored.
    always_comb begin
        state_n     = state;
        angle_n     = angle;
        dir_n       = dir;
        dwell_n     = dwell_cnt;
        tmo_n       = tmo_cnt;
        smp_angle_n = smp_angle;
        smp_range_n = smp_range;
        smp_dir_n   = smp_dir;
        smp_tmo_n   = smp_tmo;
        sweep_done  = 1'b0;

        case (state)
            S_IDLE: begin
                angle_n = A_MIN;
                if (start && !stop) begin
                    state_n = S_SETTLE;
                    dir_n   = 1'b0;
                    dwell_n = '0;
                end
            end
            S_SETTLE: begin
                if (dwell_cnt == DWELL_LAST) begin
                    state_n = S_MEASURE;
                    tmo_n   = '0;
                end else begin
                    dwell_n = dwell_cnt + DWELL_W'(1);
                end
            end
            S_MEASURE: begin
                if (meas_valid) begin
                    state_n     = S_EMIT;
                    smp_range_n = range_in;
                    smp_tmo_n   = 1'b0;
                    smp_angle_n = angle;
                    smp_dir_n   = dir;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_n     = S_EMIT;
                    smp_range_n = '1;
                    smp_tmo_n   = 1'b1;
                    smp_angle_n = angle;
                    smp_dir_n   = dir;
                end else begin
                    tmo_n = tmo_cnt + TMO_W'(1);
                end
            end
            S_EMIT: begin
                state_n = S_STEP;
            end
            S_STEP: begin
                dwell_n = '0;
                if (!dir) begin
                    state_n = S_SETTLE;
                    if (angle < A_MAX) begin
                        angle_n = up_next;
                    end else begin
                        dir_n   = 1'b1;
                        angle_n = dn_next;
                    end
                end else if (angle > A_MIN) begin
                    state_n = S_SETTLE;
                    angle_n = dn_next;
                end else begin
                    sweep_done = 1'b1;
                    if (continuous) begin
                        state_n = S_SETTLE;
                        dir_n   = 1'b0;
                        angle_n = A_RESTART;
                    end else begin
                        state_n = S_IDLE;
                        angle_n = A_MIN;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                angle_n = A_MIN;
            end
        endcase

        // Abort overrides everything; the EMIT strobe is decoded from the current state and still completes.
        if (stop && (state != S_IDLE)) begin
            state_n    = S_IDLE;
            angle_n    = A_MIN;
            dir_n      = 1'b0;
            dwell_n    = '0;
            tmo_n      = '0;
            sweep_done = 1'b0;
        end
    end

    assign servo_angle  = angle;
    assign meas_req     = (state == S_MEASURE);
    assign sample_valid = (state == S_EMIT);
    assign sample_angle = smp_angle;
    assign sample_range = smp_range;
    assign sample_dir   = smp_dir;
    assign sample_tmo   = smp_tmo;
    assign busy         = (state != S_IDLE);
    assign state_dbg    = state;

endmodule
